// File: rtl/debug_reg_dump_if.sv
// Byte stream from the register dump unit to the debug UART transmitter.
// A byte moves on a rising edge where tx_valid and tx_ready are both high.
interface debug_reg_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/debug_reg_dump.sv
// Debug register-file dump: walks registers 0..CELDAS-1 through the register
// file read port and serializes each word MSB byte first onto a valid/ready
// byte stream toward the debug UART transmitter.
module debug_reg_dump #(
    parameter int NBITS  = 32,
    parameter int REGS   = 5,
    parameter int CELDAS = 32,
    parameter int RD_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_Start,
    output logic                o_Busy,
    output logic [REGS-1:0]     o_RegAddr,
    input  logic [NBITS-1:0]    i_RegData,
    debug_reg_dump_if.master    tx,
    output logic                o_Done
);

    localparam int BYTES = NBITS / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW   = $clog2(RD_LAT + 2);

    localparam logic [REGS-1:0] LAST_REG  = REGS'(CELDAS - 1);
    localparam logic [REGS-1:0] REG_ZERO  = REGS'(0);
    localparam logic [REGS-1:0] REG_ONE   = REGS'(1);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [BCW-1:0]  BYTE_ZERO = BCW'(0);
    localparam logic [BCW-1:0]  BYTE_ONE  = BCW'(1);
    localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(RD_LAT + 1);
    localparam logic [WCW-1:0]  WAIT_ZERO = WCW'(0);
    localparam logic [WCW-1:0]  WAIT_ONE  = WCW'(1);

    // Reject geometries that cannot be serialized or addressed.
    if (NBITS % 8 != 0) begin : g_bad_nbits
        $error("debug_reg_dump: NBITS must be a multiple of 8");
    end
    if (CELDAS > (2 ** REGS)) begin : g_bad_celdas
        $error("debug_reg_dump: CELDAS exceeds the register address space");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q;
    logic [REGS-1:0]   reg_cnt_q;
    logic [BCW-1:0]    byte_cnt_q;
    logic [WCW-1:0]    wait_cnt_q;
    logic [NBITS-1:0]  shift_q;
    logic              busy_q;
    logic [REGS-1:0]   reg_addr_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              done_q;

    // Dump sequencer: address, wait for read data, capture, stream bytes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            reg_cnt_q  <= REG_ZERO;
            byte_cnt_q <= BYTE_ZERO;
            wait_cnt_q <= WAIT_ZERO;
            shift_q    <= {NBITS{1'b0}};
            busy_q     <= 1'b0;
            reg_addr_q <= REG_ZERO;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (i_Start) begin
                        state_q   <= S_ADDR;
                        busy_q    <= 1'b1;
                        reg_cnt_q <= REG_ZERO;
                    end
                end
                S_ADDR: begin
                    reg_addr_q <= reg_cnt_q;
                    wait_cnt_q <= WAIT_LOAD;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - WAIT_ONE;
                    // Counter hits zero on this edge: read data is now valid.
                    if (wait_cnt_q == WAIT_ONE) begin
                        shift_q    <= i_RegData << 4'd8;
                        tx_data_q  <= i_RegData[NBITS-1 -: 8];
                        tx_valid_q <= 1'b1;
                        byte_cnt_q <= BYTE_ZERO;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Without ready, data and valid simply hold.
                    if (tx.tx_ready) begin
                        byte_cnt_q <= byte_cnt_q + BYTE_ONE;
                        if (byte_cnt_q == LAST_BYTE) begin
                            tx_valid_q <= 1'b0;
                            if (reg_cnt_q == LAST_REG) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                busy_q     <= 1'b0;
                                reg_addr_q <= REG_ZERO;
                            end else begin
                                reg_cnt_q <= reg_cnt_q + REG_ONE;
                                state_q   <= S_ADDR;
                            end
                        end else begin
                            tx_data_q <= shift_q[NBITS-1 -: 8];
                            shift_q   <= shift_q << 4'd8;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    reg_addr_q <= REG_ZERO;
                    tx_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_Busy      = busy_q;
    assign o_RegAddr   = reg_addr_q;
    assign o_Done      = done_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_debug_reg_dump.sv
// Self-checking bench for debug_reg_dump: register file models, byte
// scoreboards, timing of Busy/Done, backpressure, ignored restart, async
// reset mid-dump and a small CELDAS=4 / RD_LAT=2 instance.
module tb_debug_reg_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic        busy, busy2, done, done2;
    logic [4:0]  regaddr, regaddr2, a1_2;
    logic [31:0] rdata, rdata2;
    logic [31:0] mem [32];

    int checks = 0;
    int failures = 0;
    int acc1 = 0;
    int done1_cnt = 0;
    int done2_cnt = 0;

    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] e1, e2;

    debug_reg_dump_if txif ();
    debug_reg_dump_if txif2 ();

    debug_reg_dump #(.NBITS(32), .REGS(5), .CELDAS(32), .RD_LAT(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_Start(start), .o_Busy(busy),
        .o_RegAddr(regaddr), .i_RegData(rdata), .tx(txif), .o_Done(done)
    );

    debug_reg_dump #(.NBITS(32), .REGS(5), .CELDAS(4), .RD_LAT(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_Start(start2), .o_Busy(busy2),
        .o_RegAddr(regaddr2), .i_RegData(rdata2), .tx(txif2), .o_Done(done2)
    );

    always #5 clk = ~clk;

    // Register file with one edge of read latency.
    always @(posedge clk) rdata <= mem[regaddr];

    // Register file with two edges of read latency.
    always @(posedge clk) begin
        a1_2   <= regaddr2;
        rdata2 <= mem[a1_2];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard for the default instance: handshakes seen before the edge.
    always @(negedge clk) begin
        if (txif.tx_valid && txif.tx_ready) begin
            if (q1.size() == 0) begin
                chk("sb1_extra_byte", {24'h0, txif.tx_data}, 32'hFFFF_FFFF);
            end else begin
                e1 = q1.pop_front();
                chk("sb1_byte", {24'h0, txif.tx_data}, {24'h0, e1});
            end
            acc1++;
        end
        if (done) done1_cnt++;
    end

    // Scoreboard for the small instance.
    always @(negedge clk) begin
        if (txif2.tx_valid && txif2.tx_ready) begin
            if (q2.size() == 0) begin
                chk("sb2_extra_byte", {24'h0, txif2.tx_data}, 32'hFFFF_FFFF);
            end else begin
                e2 = q2.pop_front();
                chk("sb2_byte", {24'h0, txif2.tx_data}, {24'h0, e2});
            end
        end
        if (done2) done2_cnt++;
    end

    task automatic push_exp(input int nregs, input bit second);
        logic [31:0] w;
        for (int k = 0; k < nregs; k++) begin
            w = mem[k];
            for (int b = 0; b < 4; b++) begin
                if (second) q2.push_back(w[31-8*b -: 8]);
                else        q1.push_back(w[31-8*b -: 8]);
            end
        end
    endtask

    task automatic do_dump(input string tag, input bit start_mid, input bit bp);
        int  n;
        int  busy_n;
        int  done_n;
        int  exp_n;
        bit  sm_done;
        bit  bp_done;
        sm_done = 1'b0;
        bp_done = 1'b0;
        exp_n = bp ? 229 : 224;
        push_exp(32, 1'b0);
        acc1 = 0;
        @(posedge clk); #1;
        chk({tag, "_done_low_before"}, 32'(done), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = 0;
        done_n = -1;
        if (busy) busy_n++;
        n = 1;
        while (n <= 2000 && done_n < 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_n++;
            if (done) done_n = n;
            if (start_mid && !sm_done && acc1 == 41) begin
                start = 1'b1;
                sm_done = 1'b1;
            end
            if (bp && !bp_done && acc1 == 18 && txif.tx_valid) begin
                txif.tx_ready = 1'b0;
                bp_done = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk({tag, "_hold_data"}, {24'h0, txif.tx_data}, 32'h0000_00FF);
                    chk({tag, "_hold_valid"}, 32'(txif.tx_valid), 32'd1);
                    @(posedge clk); #1;
                    n++;
                    if (busy) busy_n++;
                end
                txif.tx_ready = 1'b1;
            end
            n++;
        end
        chk({tag, "_done_cycle"}, 32'(done_n), 32'(exp_n));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_n));
        chk({tag, "_addr_after"}, {27'h0, regaddr}, 32'd0);
        chk({tag, "_bytes_left"}, 32'(q1.size()), 32'd0);
        chk({tag, "_byte_count"}, 32'(acc1), 32'd128);
    endtask

    task automatic reset_mid_dump();
        push_exp(32, 1'b0);
        acc1 = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (acc1 >= 29) break;
            @(posedge clk); #1;
        end
        chk("rst_reached_reg7", 32'(acc1 >= 29), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_async", 32'(busy), 32'd0);
        chk("rst_valid_async", 32'(txif.tx_valid), 32'd0);
        chk("rst_data_async", {24'h0, txif.tx_data}, 32'd0);
        chk("rst_addr_async", {27'h0, regaddr}, 32'd0);
        q1.delete();
        #10;
        rst_n = 1'b1;
        do_dump("after_rst", 1'b0, 1'b0);
    endtask

    task automatic small_dump();
        int busy_n;
        int done_n;
        push_exp(4, 1'b1);
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        busy_n = busy2 ? 1 : 0;
        done_n = -1;
        for (int n = 1; n <= 500 && done_n < 0; n++) begin
            @(posedge clk); #1;
            if (busy2) busy_n++;
            if (done2) done_n = n;
        end
        chk("small_done_cycle", 32'(done_n), 32'd32);
        chk("small_busy_cycles", 32'(busy_n), 32'd32);
        chk("small_bytes_left", 32'(q2.size()), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        txif.tx_ready  = 1'b1;
        txif2.tx_ready = 1'b1;
        for (int k = 0; k < 32; k++) mem[k] = 32'h0000_0100 * k + k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", {27'h0, regaddr}, 32'd0);
        chk("reset_data", {24'h0, txif.tx_data}, 32'd0);
        chk("reset_valid", 32'(txif.tx_valid), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        do_dump("basic", 1'b0, 1'b0);
        do_dump("b2b", 1'b0, 1'b0);
        do_dump("start_mid", 1'b1, 1'b0);
        mem[4] = 32'h3FFF_FFFE;
        do_dump("backpressure", 1'b0, 1'b1);
        reset_mid_dump();
        small_dump();

        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done1_cnt), 32'd5);
        chk("small_done_pulses", 32'(done2_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
